// File: rtl/sd_spi_responder_if.sv
// Host SPI bus of an SD card in SPI mode, plus the card's byte-fetch and command-status signals.
interface sd_spi_responder_if;
  logic        spi_clk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        rd_req;
  logic [25:0] rd_block;
  logic [8:0]  rd_index;
  logic [7:0]  rd_data;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        in_idle;

  modport slave (
    input  spi_clk, cs, mosi, rd_data,
    output miso, rd_req, rd_block, rd_index, cmd_valid, cmd_index, cmd_arg, in_idle
  );
  modport master (
    output spi_clk, cs, mosi, rd_data,
    input  miso, rd_req, rd_block, rd_index, cmd_valid, cmd_index, cmd_arg, in_idle
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: oversamples the host SPI bus, decodes command frames and
// answers CMD0/8/55/41/58/17 with framed responses; read data comes from a byte-fetch port.
module sd_spi_responder #(
  parameter int unsigned ACMD41_BUSY_COUNT = 2,
  parameter int unsigned NCR_BYTES         = 1
) (
  input logic               clk,
  input logic               rst,
  sd_spi_responder_if.slave bus
);
  typedef enum logic [2:0] {S_HUNT, S_CMD_RX, S_NCR, S_RESP, S_TOKEN, S_DATA, S_CRC} state_t;
  state_t state;

  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_bits;
  logic [2:0]  byte_cnt;
  logic [5:0]  frame_index;
  logic [31:0] frame_arg;
  logic [1:0]  decode_pipe;
  logic [39:0] resp_buf;
  logic [2:0]  resp_left;
  logic        data_go, app_cmd;
  logic [15:0] acmd_cnt;
  logic        fetch_d1;
  logic [7:0]  tx_shift;

  logic        sclk_rise, sclk_fall, byte_done, cs_high;
  logic [7:0]  rx_byte;
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_high   = cs_sync[1];
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_bits, mosi_sync[1]};

  // Response bytes packed MSB-first; dec_left is the number of bytes following R1.
  logic [39:0] dec_buf;
  logic [2:0]  dec_left;
  logic        dec_go, dec_idle;
  logic [15:0] dec_acmd;
  always_comb begin
    dec_buf  = {7'b0, bus.in_idle, 32'hFFFF_FFFF};
    dec_left = '0;
    dec_go   = 1'b0;
    dec_idle = bus.in_idle;
    dec_acmd = acmd_cnt;
    case (frame_index)
      6'd0: begin
        dec_idle = 1'b1;
        dec_acmd = '0;
        dec_buf[39:32] = 8'h01;
      end
      6'd8: begin
        dec_buf  = {7'b0, bus.in_idle, 16'h0000, 4'h0, frame_arg[11:8] & 4'h1, frame_arg[7:0]};
        dec_left = 3'd4;
      end
      6'd55: begin
        dec_left = '0;
      end
      6'd41: begin
        if (!app_cmd) begin
          dec_buf[39:32] = {5'b0, 1'b1, 1'b0, bus.in_idle};
        end else if (32'(acmd_cnt) < ACMD41_BUSY_COUNT) begin
          dec_acmd = acmd_cnt + 16'd1;
          dec_buf[39:32] = 8'h01;
        end else begin
          dec_idle = 1'b0;
          dec_buf[39:32] = 8'h00;
        end
      end
      6'd58: begin
        dec_buf  = {7'b0, bus.in_idle, 32'hC0FF_8000};
        dec_left = 3'd4;
      end
      6'd17: begin
        if (bus.in_idle) begin
          dec_buf[39:32] = 8'h05;
        end else begin
          dec_buf[39:32] = 8'h00;
          dec_go = 1'b1;
        end
      end
      default: dec_buf[39:32] = {5'b0, 1'b1, 1'b0, bus.in_idle};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync     <= '0;
      cs_sync       <= '1;
      mosi_sync     <= '1;
      sclk_prev     <= 1'b0;
      state         <= S_HUNT;
      bit_cnt       <= '0;
      rx_bits       <= '0;
      byte_cnt      <= '0;
      frame_index   <= '0;
      frame_arg     <= '0;
      decode_pipe   <= '0;
      resp_buf      <= '1;
      resp_left     <= '0;
      data_go       <= 1'b0;
      app_cmd       <= 1'b0;
      acmd_cnt      <= '0;
      fetch_d1      <= 1'b0;
      tx_shift      <= '1;
      bus.miso      <= 1'b1;
      bus.rd_req    <= 1'b0;
      bus.rd_block  <= '0;
      bus.rd_index  <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_index <= '0;
      bus.cmd_arg   <= '0;
      bus.in_idle   <= 1'b1;
    end else begin
      sclk_sync     <= {sclk_sync[0], bus.spi_clk};
      cs_sync       <= {cs_sync[0], bus.cs};
      mosi_sync     <= {mosi_sync[0], bus.mosi};
      sclk_prev     <= sclk_sync[1];
      bus.cmd_valid <= 1'b0;
      bus.rd_req    <= 1'b0;
      fetch_d1      <= bus.rd_req;
      decode_pipe   <= {decode_pipe[0], 1'b0};

      if (decode_pipe[1]) begin
        bus.cmd_valid <= 1'b1;
        bus.cmd_index <= frame_index;
        bus.cmd_arg   <= frame_arg;
        bus.in_idle   <= dec_idle;
        acmd_cnt      <= dec_acmd;
        app_cmd       <= (frame_index == 6'd55);
        data_go       <= dec_go;
        resp_buf      <= dec_buf;
        resp_left     <= dec_left;
        if (dec_go) bus.rd_block <= frame_arg[25:0];
      end

      if (cs_high) begin
        state    <= S_HUNT;
        bit_cnt  <= '0;
        tx_shift <= '1;
        bus.miso <= 1'b1;
        fetch_d1 <= 1'b0;
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_bits <= {rx_bits[5:0], mosi_sync[1]};
        end
        if (sclk_fall) begin
          bus.miso <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
        // Data bytes arrive two clk after the fetch, still well ahead of the next falling edge.
        if (fetch_d1) tx_shift <= bus.rd_data;
        if (byte_done) begin
          tx_shift <= 8'hFF;
          case (state)
            S_HUNT: begin
              if (rx_byte[7:6] == 2'b01) begin
                frame_index <= rx_byte[5:0];
                byte_cnt    <= '0;
                state       <= S_CMD_RX;
              end
            end
            S_CMD_RX: begin
              if (byte_cnt == 3'd4) begin
                byte_cnt    <= '0;
                decode_pipe <= {decode_pipe[0], 1'b1};
                state       <= S_NCR;
              end else begin
                frame_arg <= {frame_arg[23:0], rx_byte};
                byte_cnt  <= byte_cnt + 3'd1;
              end
            end
            S_NCR: begin
              if (byte_cnt == 3'(NCR_BYTES - 1)) begin
                tx_shift <= resp_buf[39:32];
                resp_buf <= {resp_buf[31:0], 8'hFF};
                state    <= S_RESP;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
            S_RESP: begin
              if (resp_left != '0) begin
                tx_shift  <= resp_buf[39:32];
                resp_buf  <= {resp_buf[31:0], 8'hFF};
                resp_left <= resp_left - 3'd1;
              end else if (data_go) begin
                tx_shift <= 8'hFE;
                state    <= S_TOKEN;
              end else begin
                state <= S_HUNT;
              end
            end
            S_TOKEN: begin
              bus.rd_req   <= 1'b1;
              bus.rd_index <= '0;
              state        <= S_DATA;
            end
            S_DATA: begin
              if (bus.rd_index == 9'd511) begin
                bus.rd_index <= '0;
                byte_cnt     <= '0;
                state        <= S_CRC;
              end else begin
                bus.rd_index <= bus.rd_index + 9'd1;
                bus.rd_req   <= 1'b1;
              end
            end
            S_CRC: begin
              if (byte_cnt == '0) byte_cnt <= 3'd1;
              else state <= S_HUNT;
            end
            default: state <= S_HUNT;
          endcase
        end
      end
    end
  end
endmodule
